dec_seq_onehot: RTL and testbench

- Parametrised N-to-2^N one-hot decoder with a registered output and a valid/ready input handshake.
- Adds a timed scan mode that steps the one-hot output through every channel, each held for a programmable dwell time.
- Succeeds the combinational 2-to-4 decoder. Drives channel-select and enable strobes for downstream mux and peripheral banks.

---
 rtl/dec_seq_pkg.sv | 24 ++
 rtl/dec_seq_dwell_cnt.sv | 31 +++
 rtl/dec_seq_onehot.sv | 150 +++++++++++++++
 tb/tb_dec_seq_onehot.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/dec_seq_pkg.sv
// Shared types and helpers for the dec_seq_onehot decoder/scanner.
package dec_seq_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

  localparam logic MODE_DECODE = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Widest select the helper supports; callers truncate to their own 2^SEL_W.
  localparam int SEL_MAX_W = 8;
  localparam int OH_MAX_W  = 1 << SEL_MAX_W;

  function automatic logic [OH_MAX_W-1:0] onehot(input logic [SEL_MAX_W-1:0] sel,
                                                 input logic                 en);
    logic [OH_MAX_W-1:0] v;
    v = '0;
    if (en) v[sel] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/dec_seq_dwell_cnt.sv
// Loadable down-counter with zero flag; holds at zero until reloaded.
module dec_seq_dwell_cnt #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [DWELL_W-1:0] load_val,
  input  logic               dec,
  output logic               zero
);

  logic [DWELL_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/dec_seq_onehot.sv
// N-to-2^N registered one-hot decoder with valid/ready input and a timed scan mode.
// Scan mode is built only when DEC_SEQ_SCAN_EN is defined; otherwise every request decodes.
module dec_seq_onehot
  import dec_seq_pkg::*;
#(
  parameter int SEL_W   = 2,
  parameter int DWELL_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [SEL_W-1:0]      in_sel,
  input  logic                  in_en,
  input  logic                  in_mode,
  input  logic [DWELL_W-1:0]    in_dwell,
  output logic [(1<<SEL_W)-1:0] out_y,
  output logic                  out_valid,
  output logic                  busy,
  output logic                  scan_done
);

  localparam int OUT_W = 1 << SEL_W;

  function automatic logic [OUT_W-1:0] dec_vec(input logic [SEL_W-1:0] sel, input logic en);
    return OUT_W'(onehot(SEL_MAX_W'(sel), en));
  endfunction

  logic [OUT_W-1:0] out_y_q, out_y_d;
  logic             out_valid_q, out_valid_d;
  logic             accept;

  assign accept = in_valid & in_ready;

`ifdef DEC_SEQ_SCAN_EN
  state_e             state_q, state_d;
  logic [SEL_W-1:0]   idx_q, idx_d;
  logic [SEL_W-1:0]   steps_q, steps_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic               scan_done_q, scan_done_d;
  logic               cnt_load, cnt_dec, cnt_zero;
  logic [DWELL_W-1:0] cnt_load_val;

  dec_seq_dwell_cnt #(.DWELL_W(DWELL_W)) u_dwell_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    steps_d      = steps_q;
    dwell_d      = dwell_q;
    out_y_d      = out_y_q;
    out_valid_d  = 1'b0;
    scan_done_d  = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = dwell_q;
    cnt_dec      = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (in_mode == MODE_SCAN) begin
            state_d      = SCAN;
            idx_d        = in_sel;
            steps_d      = '0;
            dwell_d      = in_dwell;
            cnt_load     = 1'b1;
            cnt_load_val = in_dwell;
            out_y_d      = dec_vec(in_sel, 1'b1);
          end else begin
            out_y_d     = dec_vec(in_sel, in_en);
            out_valid_d = 1'b1;
          end
        end
      end
      SCAN: begin
        if (!cnt_zero) begin
          cnt_dec = 1'b1;
        end else if (steps_q == '1) begin
          // Every channel has been visited once: blank the output and hand back to IDLE.
          state_d     = IDLE;
          out_y_d     = '0;
          scan_done_d = 1'b1;
        end else begin
          idx_d    = idx_q + 1'b1;
          steps_d  = steps_q + 1'b1;
          cnt_load = 1'b1;
          out_y_d  = dec_vec(idx_d, 1'b1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      steps_q     <= '0;
      dwell_q     <= '0;
      scan_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      steps_q     <= steps_d;
      dwell_q     <= dwell_d;
      scan_done_q <= scan_done_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == SCAN);
  assign scan_done = scan_done_q;
`else
  logic unused_scan_inputs;
  assign unused_scan_inputs = ^{in_mode, in_dwell};

  always_comb begin
    out_y_d     = out_y_q;
    out_valid_d = 1'b0;
    if (accept) begin
      out_y_d     = dec_vec(in_sel, in_en);
      out_valid_d = 1'b1;
    end
  end

  assign in_ready  = 1'b1;
  assign busy      = 1'b0;
  assign scan_done = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_y_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_y_q     <= out_y_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_y     = out_y_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_dec_seq_onehot.sv
// Self-checking bench for dec_seq_onehot (SEL_W=2, DWELL_W=8); follows DEC_SEQ_SCAN_EN like the design.
module tb_dec_seq_onehot;

`ifdef DEC_SEQ_SCAN_EN
  localparam bit SCAN_ON = 1'b1;
`else
  localparam bit SCAN_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [1:0] in_sel = '0;
  logic       in_en = 1'b0;
  logic       in_mode = 1'b0;
  logic [7:0] in_dwell = '0;
  logic [3:0] out_y;
  logic       out_valid, busy, scan_done;

  int n_chk = 0;
  int n_pass = 0;
  bit checking = 1'b0;

  dec_seq_onehot #(.SEL_W(2), .DWELL_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .in_en     (in_en),
    .in_mode   (in_mode),
    .in_dwell  (in_dwell),
    .out_y     (out_y),
    .out_valid (out_valid),
    .busy      (busy),
    .scan_done (scan_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: a scan request expands into its full list of future output cycles.
  typedef struct {
    logic [3:0] y;
    logic       busy;
    logic       done;
  } ent_t;

  ent_t       sched[$];
  logic [3:0] m_y = '0;
  logic       m_valid = 1'b0, m_busy = 1'b0, m_done = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sched.delete();
      m_y = '0; m_valid = 1'b0; m_busy = 1'b0; m_done = 1'b0;
    end else begin
      ent_t e;
      m_valid = 1'b0;
      m_done  = 1'b0;
      if (sched.size() == 0 && in_valid) begin
        if (SCAN_ON && in_mode) begin
          for (int k = 0; k < 4; k++)
            for (int d = 0; d <= int'(in_dwell); d++)
              sched.push_back('{4'(1 << ((int'(in_sel) + k) % 4)), 1'b1, 1'b0});
          sched.push_back('{4'b0000, 1'b0, 1'b1});
        end else begin
          m_y     = in_en ? 4'(1 << in_sel) : 4'b0000;
          m_valid = 1'b1;
          m_busy  = 1'b0;
        end
      end
      if (sched.size() > 0 && !m_valid) begin
        e = sched.pop_front();
        m_y = e.y; m_busy = e.busy; m_done = e.done;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && checking) begin
      check("y", {28'd0, out_y}, {28'd0, m_y});
      check("valid", {31'd0, out_valid}, {31'd0, m_valid});
      check("busy", {31'd0, busy}, {31'd0, m_busy});
      check("done", {31'd0, scan_done}, {31'd0, m_done});
      check("ready", {31'd0, in_ready}, {31'd0, (sched.size() == 0)});
      check("onehot0", $countones(out_y) <= 1, 1);
    end
  end

  task automatic send(input logic [1:0] s, input logic e, input logic m, input logic [7:0] d,
                      output int waited);
    in_sel = s; in_en = e; in_mode = m; in_dwell = d; in_valid = 1'b1;
    waited = 0;
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    check("send_ready", {31'd0, in_ready}, 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    #4000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, busy_cnt;
    logic [3:0] sweep [4];
    logic [3:0] seq4 [9];
    logic [3:0] seq6 [5];
    logic       prev_ready;
    sweep = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    seq4  = '{4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0000};
    seq6  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000};

    #1 rst_n = 1'b0;
    #20;
    check("rst_y", {28'd0, out_y}, 0);
    check("rst_valid", {31'd0, out_valid}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, scan_done}, 0);
    check("rst_ready", {31'd0, in_ready}, 1);
    @(negedge clk);
    rst_n = 1'b1;
    checking = 1'b1;
    @(negedge clk);

    // 1: reset during a running scan
    send(2'd1, 1'b1, 1'b1, 8'd5, w);
    repeat (3) @(negedge clk);
`ifdef DEC_SEQ_SCAN_EN
    check("t1_busy_before", {31'd0, busy}, 1);
`endif
    #2 rst_n = 1'b0;
    #1;
    check("t1_y", {28'd0, out_y}, 0);
    check("t1_busy", {31'd0, busy}, 0);
    check("t1_done", {31'd0, scan_done}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t1_ready", {31'd0, in_ready}, 1);
    check("t1_done_after", {31'd0, scan_done}, 0);

    // 2: back-to-back decode sweep
    for (int k = 0; k < 4; k++) begin
      in_sel = 2'(k); in_en = 1'b1; in_mode = 1'b0; in_valid = 1'b1;
      @(negedge clk);
      check("t2_y", {28'd0, out_y}, {28'd0, sweep[k]});
      check("t2_valid", {31'd0, out_valid}, 1);
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("t2_hold", {28'd0, out_y}, 32'h8);

    // 3: disabled decode
    send(2'd2, 1'b0, 1'b0, 8'd0, w);
    check("t3_y", {28'd0, out_y}, 0);
    check("t3_valid", {31'd0, out_valid}, 1);

    // 4: scan from channel 2, two cycles per channel
    send(2'd2, 1'b1, 1'b1, 8'd1, w);
`ifdef DEC_SEQ_SCAN_EN
    busy_cnt = 0;
    for (int i = 0; i < 9; i++) begin
      check("t4_y", {28'd0, out_y}, {28'd0, seq4[i]});
      check("t4_done", {31'd0, scan_done}, (i == 8) ? 1 : 0);
      busy_cnt += int'(busy);
      @(negedge clk);
    end
    check("t4_busy_cycles", busy_cnt, 8);
`else
    check("t4_y", {28'd0, out_y}, 32'h4);
    check("t4_valid", {31'd0, out_valid}, 1);
`endif

    // 5: decode request held off by a running scan
    send(2'd0, 1'b1, 1'b1, 8'd0, w);
    send(2'd3, 1'b1, 1'b0, 8'd0, w);
`ifdef DEC_SEQ_SCAN_EN
    check("t5_wait", w, 4);
`else
    check("t5_wait", w, 0);
`endif
    check("t5_y", {28'd0, out_y}, 32'h8);
    check("t5_valid", {31'd0, out_valid}, 1);
    @(negedge clk);

    // 6: scan with zero dwell
    send(2'd0, 1'b1, 1'b1, 8'd0, w);
`ifdef DEC_SEQ_SCAN_EN
    for (int i = 0; i < 5; i++) begin
      check("t6_y", {28'd0, out_y}, {28'd0, seq6[i]});
      check("t6_done", {31'd0, scan_done}, (i == 4) ? 1 : 0);
      @(negedge clk);
    end
`else
    check("t6_y", {28'd0, out_y}, 32'h1);
    check("t6_valid", {31'd0, out_valid}, 1);
    check("t6_busy", {31'd0, busy}, 0);
`endif

    // Random traffic; inputs stay stable while a request waits for in_ready.
    prev_ready = in_ready;
    for (int c = 0; c < 600; c++) begin
      if (c == 300) begin
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end else if (!(in_valid && !prev_ready)) begin
        in_valid = ($urandom_range(0, 9) < 6);
        in_sel   = 2'($urandom_range(0, 3));
        in_en    = 1'($urandom_range(0, 1));
        in_mode  = ($urandom_range(0, 3) == 0);
        in_dwell = 8'($urandom_range(0, 3));
      end
      prev_ready = in_ready;
      @(negedge clk);
    end
    in_valid = 1'b0;
    repeat (40) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
